// File: rtl/flow_packet_manager.sv
// flow_packet_manager
// Issues packet commands for one traffic flow at a run-time programmable rate.
// A fractional token-bucket credit accumulator paces the commands, so no
// per-rate divider counter is needed. The flow runs continuously or for a
// fixed-length burst, handshakes with the shared arbiter and the command FIFO,
// and reports the number of packets sent and burst completion.

module flow_packet_manager #(
  parameter int unsigned  ID        = 0,
  parameter int unsigned  FRAC_BITS = 16,
  parameter int unsigned  CREDIT_W  = 32,
  parameter int unsigned  COUNT_W   = 32,
  parameter int unsigned  MIN_SIZE  = 64,
  parameter int unsigned  MAX_SIZE  = 1518,
  parameter logic [7:0]   PAYLOAD   = 8'h1A,
  parameter logic [47:0]  MAC_D     = 48'hBC9A78563412,
  parameter logic [47:0]  MAC_S     = 48'h111111111111,
  parameter logic [15:0]  ETHERTYPE = 16'h0800
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_enable,
  input  logic                cfg_mode,
  input  logic [10:0]         cfg_size,
  input  logic [CREDIT_W-1:0] cfg_rate_inc,
  input  logic [COUNT_W-1:0]  cfg_burst_len,
  output logic                arb_request,
  output logic                arb_ack,
  input  logic                arb_grant,
  input  logic                fifo_wr_ready,
  output logic                fifo_wr_enable,
  output logic [10:0]         size,
  output logic [47:0]         d_mac,
  output logic [47:0]         s_mac,
  output logic [15:0]         ethertype,
  output logic [7:0]          payload,
  output logic [COUNT_W-1:0]  pkt_count,
  output logic                done,
  output logic                overflow
);

  // Frame size clamp limits in the width of the size field.
  localparam logic [10:0] MIN_SZ = 11'(MIN_SIZE);
  localparam logic [10:0] MAX_SZ = 11'(MAX_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CREDIT,
    S_REQUEST,
    S_WRITE,
    S_DONE
  } state_t;

  // Header constants are presented least-significant byte first.
  function automatic logic [47:0] rev_bytes48(input logic [47:0] v);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[8*i +: 8] = v[8*(5-i) +: 8];
    end
    return r;
  endfunction

  assign d_mac     = rev_bytes48(MAC_D);
  assign s_mac     = rev_bytes48(MAC_S);
  assign ethertype = {ETHERTYPE[7:0], ETHERTYPE[15:8]};
  assign payload   = PAYLOAD;

  // The arbiter is told this flow can be served whenever it is out of reset.
  assign arb_ack = ~rst;

  // Registered state.
  state_t               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [COUNT_W-1:0]   pkt_count_q, pkt_count_d;
  logic [COUNT_W-1:0]   burst_len_q, burst_len_d;
  logic [10:0]          size_q, size_d;
  logic                 mode_q, mode_d;
  logic                 overflow_q, overflow_d;
  logic                 arb_request_q;
  logic                 fifo_wr_enable_q;
  logic                 done_q;

  // Combinational helpers.
  logic [10:0]          size_clamped;
  logic [CREDIT_W-1:0]  cost;
  logic                 accept;
  logic                 accruing;
  logic [CREDIT_W:0]    credit_sum;

  // Clamp the requested frame size into the legal Ethernet range.
  always_comb begin
    if (cfg_size < MIN_SZ) begin
      size_clamped = MIN_SZ;
    end else if (cfg_size > MAX_SZ) begin
      size_clamped = MAX_SZ;
    end else begin
      size_clamped = cfg_size;
    end
  end

  // Packet cost in credit units: whole bytes shifted into the integer part.
  assign cost = CREDIT_W'({size_q, {FRAC_BITS{1'b0}}});

  // A packet is committed when grant and ready coincide while requesting.
  assign accept   = (state_q == S_REQUEST) && arb_grant && fifo_wr_ready;
  assign accruing = (state_q == S_WAIT_CREDIT) || (state_q == S_REQUEST) ||
                    (state_q == S_WRITE);

  // One extra bit of headroom detects saturation; credit never drops below
  // cost while requesting, so the subtraction cannot underflow.
  always_comb begin
    credit_sum = {1'b0, credit_q} + {1'b0, cfg_rate_inc};
    if (accept) begin
      credit_sum = credit_sum - {1'b0, cost};
    end
  end

  // Next-state, configuration latch and credit bookkeeping.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    pkt_count_d = pkt_count_q;
    burst_len_d = burst_len_q;
    size_d      = size_q;
    mode_d      = mode_q;
    overflow_d  = overflow_q;

    if (accruing) begin
      if (credit_sum[CREDIT_W]) begin
        credit_d   = '1;
        overflow_d = 1'b1;
      end else begin
        credit_d   = credit_sum[CREDIT_W-1:0];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_enable) begin
          mode_d      = cfg_mode;
          burst_len_d = cfg_burst_len;
          size_d      = size_clamped;
          credit_d    = '0;
          pkt_count_d = '0;
          overflow_d  = 1'b0;
          if (cfg_mode && (cfg_burst_len == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_CREDIT;
          end
        end
      end

      S_WAIT_CREDIT: begin
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end else if (credit_q >= cost) begin
          state_d = S_REQUEST;
        end
      end

      // Enable is deliberately ignored: a request is never withdrawn.
      S_REQUEST: begin
        if (accept) begin
          state_d     = S_WRITE;
          pkt_count_d = pkt_count_q + COUNT_W'(1);
        end
      end

      S_WRITE: begin
        if (mode_q && (pkt_count_q == burst_len_q)) begin
          state_d = S_DONE;
        end else if (!cfg_enable) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_CREDIT;
        end
      end

      S_DONE: begin
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM register with outputs registered from the next state, so they depend
  // only on flops and clear asynchronously with reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      credit_q         <= '0;
      pkt_count_q      <= '0;
      burst_len_q      <= '0;
      size_q           <= MIN_SZ;
      mode_q           <= 1'b0;
      overflow_q       <= 1'b0;
      arb_request_q    <= 1'b0;
      fifo_wr_enable_q <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      credit_q         <= credit_d;
      pkt_count_q      <= pkt_count_d;
      burst_len_q      <= burst_len_d;
      size_q           <= size_d;
      mode_q           <= mode_d;
      overflow_q       <= overflow_d;
      arb_request_q    <= (state_d == S_REQUEST);
      fifo_wr_enable_q <= (state_d == S_WRITE);
      done_q           <= (state_d == S_DONE);
    end
  end

  assign arb_request    = arb_request_q;
  assign fifo_wr_enable = fifo_wr_enable_q;
  assign done           = done_q;
  assign size           = size_q;
  assign pkt_count      = pkt_count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_flow_packet_manager.sv
// Self-checking bench for flow_packet_manager: directed scenarios plus a
// randomized run, all compared every cycle against a behavioural model.

module tb_flow_packet_manager;

  localparam longint CREDIT_MAX = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable;
  logic        cfg_mode;
  logic [10:0] cfg_size;
  logic [31:0] cfg_rate_inc;
  logic [31:0] cfg_burst_len;
  logic        arb_request;
  logic        arb_ack;
  logic        arb_grant;
  logic        fifo_wr_ready;
  logic        fifo_wr_enable;
  logic [10:0] size;
  logic [47:0] d_mac;
  logic [47:0] s_mac;
  logic [15:0] ethertype;
  logic [7:0]  payload;
  logic [31:0] pkt_count;
  logic        done;
  logic        overflow;

  flow_packet_manager dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_enable     (cfg_enable),
    .cfg_mode       (cfg_mode),
    .cfg_size       (cfg_size),
    .cfg_rate_inc   (cfg_rate_inc),
    .cfg_burst_len  (cfg_burst_len),
    .arb_request    (arb_request),
    .arb_ack        (arb_ack),
    .arb_grant      (arb_grant),
    .fifo_wr_ready  (fifo_wr_ready),
    .fifo_wr_enable (fifo_wr_enable),
    .size           (size),
    .d_mac          (d_mac),
    .s_mac          (s_mac),
    .ethertype      (ethertype),
    .payload        (payload),
    .pkt_count      (pkt_count),
    .done           (done),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_no = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: flow phase, credit as an unbounded integer clipped to the
  // accumulator maximum, and the latched run configuration.
  // ---------------------------------------------------------------------------
  typedef enum int {P_IDLE, P_WAIT, P_REQ, P_WR, P_DONE} phase_t;

  phase_t      m_ph;
  longint      m_credit;
  logic [31:0] m_cnt;
  logic [31:0] m_blen;
  logic        m_mode;
  logic        m_ovf;
  int          m_size;

  function automatic int clamp_size(input int s);
    if (s < 64)   return 64;
    if (s > 1518) return 1518;
    return s;
  endfunction

  task automatic model_reset();
    m_ph     = P_IDLE;
    m_credit = 0;
    m_cnt    = '0;
    m_blen   = '0;
    m_mode   = 1'b0;
    m_ovf    = 1'b0;
    m_size   = 64;
  endtask

  task automatic model_step();
    phase_t nxt;
    longint cost;
    longint c;
    bit     take;
    cost = longint'(m_size) * 65536;
    take = (m_ph == P_REQ) && arb_grant && fifo_wr_ready;
    nxt  = m_ph;
    case (m_ph)
      P_IDLE: if (cfg_enable) begin
        m_mode   = cfg_mode;
        m_blen   = cfg_burst_len;
        m_size   = clamp_size(int'(cfg_size));
        m_credit = 0;
        m_cnt    = '0;
        m_ovf    = 1'b0;
        nxt      = (cfg_mode && cfg_burst_len == 0) ? P_DONE : P_WAIT;
      end
      P_WAIT: begin
        if (!cfg_enable)           nxt = P_IDLE;
        else if (m_credit >= cost) nxt = P_REQ;
      end
      P_REQ: if (take) begin
        nxt   = P_WR;
        m_cnt = m_cnt + 1;
      end
      P_WR: begin
        if (m_mode && m_cnt == m_blen) nxt = P_DONE;
        else if (!cfg_enable)          nxt = P_IDLE;
        else                           nxt = P_WAIT;
      end
      P_DONE: if (!cfg_enable) nxt = P_IDLE;
      default: nxt = P_IDLE;
    endcase
    if (m_ph == P_WAIT || m_ph == P_REQ || m_ph == P_WR) begin
      c = m_credit + longint'(cfg_rate_inc) - (take ? cost : 0);
      if (c > CREDIT_MAX) begin
        c     = CREDIT_MAX;
        m_ovf = 1'b1;
      end
      m_credit = c;
    end
    m_ph = nxt;
  endtask

  task automatic compare_all();
    check("arb_request", arb_request,    m_ph == P_REQ);
    check("wr_enable",   fifo_wr_enable, m_ph == P_WR);
    check("done",        done,           m_ph == P_DONE);
    check("pkt_count",   pkt_count,      m_cnt);
    check("size",        size,           64'(m_size));
    check("overflow",    overflow,       m_ovf);
    check("arb_ack",     arb_ack,        !rst);
  endtask

  // One clock: advance the model at the edge, compare on the falling edge.
  task automatic cycle();
    @(posedge clk);
    edge_no++;
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_out(input int n);
    cfg_enable    = 1'b0;
    arb_grant     = 1'b1;
    fifo_wr_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  int start_edge;
  int strobe_edge[3];
  int n_seen;
  int wait_n;

  initial begin
    rst           = 1'b1;
    cfg_enable    = 1'b0;
    cfg_mode      = 1'b0;
    cfg_size      = 11'd64;
    cfg_rate_inc  = '0;
    cfg_burst_len = '0;
    arb_grant     = 1'b0;
    fifo_wr_ready = 1'b0;
    model_reset();

    // Reset values and constant header fields.
    @(negedge clk);
    compare_all();
    check("d_mac",     d_mac,     48'h123456789ABC);
    check("s_mac",     s_mac,     48'h111111111111);
    check("ethertype", ethertype, 16'h0008);
    check("payload",   payload,   8'h1A);
    cycle();
    rst = 1'b0;
    cycle();
    check("ack_after_reset", arb_ack, 1'b1);

    // Continuous: one byte per cycle, 64-byte frames.
    cfg_mode = 1'b0; cfg_size = 11'd64; cfg_rate_inc = 32'd65536;
    arb_grant = 1'b1; fifo_wr_ready = 1'b1; cfg_enable = 1'b1;
    cycle();
    start_edge = edge_no;
    n_seen = 0;
    for (int i = 0; i < 300 && n_seen < 3; i++) begin
      cycle();
      if (fifo_wr_enable) begin
        strobe_edge[n_seen] = edge_no;
        n_seen++;
        check("cont_count", pkt_count, 64'(n_seen));
      end
    end
    check("cont_strobes", 64'(n_seen), 64'd3);
    if (n_seen == 3) begin
      check("cont_first", 64'(strobe_edge[0] - start_edge), 64'd66);
      check("cont_gap1",  64'(strobe_edge[1] - strobe_edge[0]), 64'd64);
      check("cont_gap2",  64'(strobe_edge[2] - strobe_edge[1]), 64'd64);
    end
    idle_out(6);

    // Burst of three at one packet of credit per cycle.
    cfg_mode = 1'b1; cfg_burst_len = 32'd3; cfg_rate_inc = 32'd64 << 16;
    cfg_enable = 1'b1;
    n_seen = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (fifo_wr_enable) n_seen++;
    end
    check("burst_strobes", 64'(n_seen), 64'd3);
    check("burst_done",    done, 1'b1);
    check("burst_count",   pkt_count, 64'd3);
    cfg_enable = 1'b0;
    cycle();
    check("burst_done_clr", done, 1'b0);
    cycle();

    // Zero-length burst completes with no strobes.
    cfg_burst_len = '0; cfg_enable = 1'b1;
    cycle();
    check("burst0_done", done, 1'b1);
    n_seen = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (fifo_wr_enable) n_seen++;
    end
    check("burst0_strobes", 64'(n_seen), 64'd0);
    idle_out(2);

    // Backpressure: grant held, FIFO not ready.
    cfg_mode = 1'b0; cfg_size = 11'd64; cfg_rate_inc = 32'd128 << 16;
    arb_grant = 1'b1; fifo_wr_ready = 1'b0; cfg_enable = 1'b1;
    wait_n = 0;
    while (!arb_request && wait_n < 20) begin
      cycle();
      wait_n++;
    end
    check("bp_req_seen", arb_request, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("bp_hold_req", arb_request, 1'b1);
      check("bp_no_wr",    fifo_wr_enable, 1'b0);
    end
    fifo_wr_ready = 1'b1;
    cycle();
    check("bp_strobe", fifo_wr_enable, 1'b1);
    fifo_wr_ready = 1'b0;
    cycle();
    check("bp_single", fifo_wr_enable, 1'b0);
    idle_out(6);

    // Size clamping, and disable while still waiting for credit.
    cfg_size = 11'd20; cfg_rate_inc = 32'd1; cfg_enable = 1'b1;
    cycle();
    check("clamp_low", size, 11'd64);
    for (int i = 0; i < 5; i++) cycle();
    cfg_enable = 1'b0;
    n_seen = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (fifo_wr_enable || arb_request) n_seen++;
    end
    check("disable_no_req", 64'(n_seen), 64'd0);
    cfg_size = 11'd2000; cfg_enable = 1'b1;
    cycle();
    check("clamp_high", size, 11'd1518);
    idle_out(2);

    // Overflow: credit saturates, stays flagged, clears on the next start.
    cfg_size = 11'd64; cfg_rate_inc = 32'hFFFF_FFFF;
    arb_grant = 1'b1; fifo_wr_ready = 1'b0; cfg_enable = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("ovf_set", overflow, 1'b1);
    fifo_wr_ready = 1'b1; cfg_enable = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check("ovf_sticky", overflow, 1'b1);
    cfg_rate_inc = 32'd65536; cfg_enable = 1'b1;
    cycle();
    check("ovf_clear", overflow, 1'b0);
    idle_out(3);

    // Reset during a write strobe, then during a held request.
    cfg_rate_inc = 32'd64 << 16; cfg_enable = 1'b1;
    wait_n = 0;
    while (!fifo_wr_enable && wait_n < 20) begin
      cycle();
      wait_n++;
    end
    check("rst_pre_wr", fifo_wr_enable, 1'b1);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("rst_wr_drop", fifo_wr_enable, 1'b0);
    check("rst_count",   pkt_count, 64'd0);
    check("rst_ack",     arb_ack, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    fifo_wr_ready = 1'b0;
    wait_n = 0;
    while (!arb_request && wait_n < 20) begin
      cycle();
      wait_n++;
    end
    check("rst_pre_req", arb_request, 1'b1);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("rst_req_drop", arb_request, 1'b0);
    check("rst_ack2",     arb_ack, 1'b0);
    @(negedge clk);
    cycle();
    rst = 1'b0;
    cfg_enable = 1'b0;
    cycle();
    check("ack_after_rst2", arb_ack, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      arb_grant     = ($urandom_range(0, 9) < 8);
      fifo_wr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 149) == 0) cfg_enable = ~cfg_enable;
      if ($urandom_range(0, 49) == 0) begin
        cfg_mode      = $urandom_range(0, 1);
        cfg_burst_len = $urandom_range(0, 4);
        if ($urandom_range(0, 3) == 0) cfg_size = 11'($urandom_range(0, 2047));
        else                           cfg_size = 11'($urandom_range(60, 200));
        if ($urandom_range(0, 19) == 0) cfg_rate_inc = 32'hF000_0000 | $urandom;
        else cfg_rate_inc = ($urandom_range(1, 300) << 16) | $urandom_range(0, 65535);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
